// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the iterative radix-2 divider cell.
package cpu_div_pkg;
  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } div_state_t;
endpackage

// File: rtl/cpu_div_cell_if.sv
// E-stage to divider handshake bundle; master is the pipeline, slave is the divider.
interface cpu_div_cell_if
  import cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             E_div_go;
  logic             E_div_signed;
  logic             div_flush;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  modport master (
    output E_src1, E_src2, E_div_go, E_div_signed, div_flush,
    input  div_busy, div_done, div_quot, div_rem
  );

  modport slave (
    input  E_src1, E_src2, E_div_go, E_div_signed, div_flush,
    output div_busy, div_done, div_quot, div_rem
  );
endinterface

// File: rtl/cpu_div_step.sv
// One combinational restoring-division step on magnitudes: shift {rem,quo} left, subtract if it fits.
module cpu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  // rem < divisor on entry, so the trial's top bit is a reliable sign.
  always_comb begin
    shifted  = {rem[WIDTH-2:0], quo[WIDTH-1]};
    trial    = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    fits     = ~trial[WIDTH];
    next_rem = fits ? trial[WIDTH-1:0] : shifted;
    next_quo = {quo[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/cpu_div_cell.sv
// Iterative signed/unsigned divider for the M stage: IDLE -> PREP -> ITER x WIDTH -> FIX.
// Optional DIV_ZERO_FAST_EN: divide-by-zero and signed overflow bypass ITER.
module cpu_div_cell
  import cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic          clk,
  input  logic          reset_n,
  cpu_div_cell_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_QUOT = WIDTH'(DIV_ZERO_QUOT);
  localparam logic [CNT_W-1:0] ITER_CNT  = CNT_W'(WIDTH);

  div_state_t       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_raw, divisor, rem_r, quo_r;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quot_r, rem_out_r;
  logic [WIDTH-1:0] res_quot, res_rem;
  logic             sign_a, sign_b, dz_r;
  logic             accept, dz_now, last_iter, load_res;

  cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  assign accept    = (state == IDLE) && bus.E_div_go && !bus.div_flush;
  assign dz_now    = (divisor == '0);
  assign last_iter = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load_res = 1'b0;
    res_quot = (sign_a ^ sign_b) ? -step_quo : step_quo;
    res_rem  = sign_a ? -step_rem : step_rem;
    if (bus.div_flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.E_div_go) state_n = PREP;
        PREP: begin
          state_n = ITER;
`ifdef DIV_ZERO_FAST_EN
          // divisor still holds the raw operand here, so overflow is b == -1
          if (dz_now) begin
            state_n  = FIX;
            load_res = 1'b1;
            res_quot = ZERO_QUOT;
            res_rem  = a_raw;
          end else if (sign_a && sign_b && a_raw == MIN_NEG && divisor == '1) begin
            state_n  = FIX;
            load_res = 1'b1;
            res_quot = MIN_NEG;
            res_rem  = '0;
          end
`endif
        end
        ITER: if (last_iter) begin
          state_n  = FIX;
          load_res = 1'b1;
          if (dz_r) begin
            res_quot = ZERO_QUOT;
            res_rem  = a_raw;
          end
        end
        FIX:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      a_raw     <= '0;
      divisor   <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dz_r      <= 1'b0;
      quot_r    <= '0;
      rem_out_r <= '0;
    end else begin
      if (accept) begin
        a_raw   <= bus.E_src1;
        divisor <= bus.E_src2;
        sign_a  <= bus.E_div_signed & bus.E_src1[WIDTH-1];
        sign_b  <= bus.E_div_signed & bus.E_src2[WIDTH-1];
      end
      if (state == PREP) begin
        quo_r   <= sign_a ? -a_raw : a_raw;
        divisor <= sign_b ? -divisor : divisor;
        rem_r   <= '0;
        dz_r    <= dz_now;
        cnt     <= ITER_CNT;
      end
      if (state == ITER) begin
        rem_r <= step_rem;
        quo_r <= step_quo;
        cnt   <= cnt - CNT_W'(1);
      end
      if (load_res) begin
        quot_r    <= res_quot;
        rem_out_r <= res_rem;
      end
    end
  end

  assign bus.div_busy = (state != IDLE);
  assign bus.div_done = (state == FIX);
  assign bus.div_quot = quot_r;
  assign bus.div_rem  = rem_out_r;
endmodule
